gpr_file: RTL and testbench

- Parametrised general-purpose register file for the convolution RISC core.
- Replaces fixed 32-bit register chains with a DEPTH x WIDTH array.
- Provides one write port, two asynchronous read ports and one in-place increment port for loop counters and address pointers.
- Sits between decode (read addresses) and writeback (write port); the loop/address unit drives the increment port.

---
 rtl/gpr_file.sv | 91 +++++++++
 tb/tb_gpr_file.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpr_file.sv
// General-purpose register file: one write port, two asynchronous read ports and an in-place increment port.
// Define GPR_BYPASS_EN to forward same-cycle write/increment results onto the read ports.
module gpr_file #(
  parameter  int WIDTH    = 32,
  parameter  int DEPTH    = 16,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             WE,
  input  logic [AW-1:0]    WADDR,
  input  logic [WIDTH-1:0] WDATA,
  input  logic             INC,
  input  logic [AW-1:0]    IADDR,
  input  logic [AW-1:0]    RADDR_A,
  output logic [WIDTH-1:0] RDATA_A,
  input  logic [AW-1:0]    RADDR_B,
  output logic [WIDTH-1:0] RDATA_B,
  output logic             INC_WRAP
);

  logic [WIDTH-1:0] regs [DEPTH];

  logic inc_blocked;
  logic inc_zero;
  logic inc_eff;
  logic inc_wrap_q;

  // A same-address write wins over the increment; register 0 ignores increments when hardwired.
  assign inc_blocked = WE && (WADDR == IADDR);
  assign inc_zero    = (ZERO_REG != 0) && (IADDR == '0);
  assign inc_eff     = INC && !inc_blocked && !inc_zero;

  for (genvar i = 0; i < DEPTH; i++) begin : g_reg
    if ((ZERO_REG != 0) && (i == 0)) begin : g_zero
      assign regs[i] = '0;
    end else begin : g_live
      logic             wr_hit;
      logic             inc_hit;
      logic [WIDTH-1:0] q;

      assign wr_hit  = WE && (WADDR == AW'(i));
      assign inc_hit = INC && (IADDR == AW'(i)) && !wr_hit;

      // NOTE: entries are discrete flops rather than a RAM macro, so clearing every entry on CLR is legal;
      // sequential state uses non-blocking assignments so all entries update from pre-edge values.
      always_ff @(posedge CLK) begin
        if (CLR) begin
          q <= '0;
        end else if (wr_hit) begin
          q <= WDATA;
        end else if (inc_hit) begin
          q <= q + WIDTH'(1);
        end
      end

      assign regs[i] = q;
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      inc_wrap_q <= 1'b0;
    end else begin
      inc_wrap_q <= inc_eff && (&regs[IADDR]);
    end
  end

  assign INC_WRAP = inc_wrap_q;

`ifdef GPR_BYPASS_EN
  logic             wr_fwd_ok;
  logic             inc_fwd_ok;
  logic [WIDTH-1:0] inc_val;

  // Forwarding is disabled during CLR so the ports show stored contents.
  assign wr_fwd_ok  = WE && !CLR && !((ZERO_REG != 0) && (WADDR == '0));
  assign inc_fwd_ok = inc_eff && !CLR;
  assign inc_val    = regs[IADDR] + WIDTH'(1);

  assign RDATA_A = (wr_fwd_ok && (RADDR_A == WADDR))  ? WDATA   :
                   (inc_fwd_ok && (RADDR_A == IADDR)) ? inc_val : regs[RADDR_A];
  assign RDATA_B = (wr_fwd_ok && (RADDR_B == WADDR))  ? WDATA   :
                   (inc_fwd_ok && (RADDR_B == IADDR)) ? inc_val : regs[RADDR_B];
`else
  assign RDATA_A = regs[RADDR_A];
  assign RDATA_B = regs[RADDR_B];
`endif

endmodule

// File: tb/tb_gpr_file.sv
// Self-checking bench for gpr_file (WIDTH=32, DEPTH=16, ZERO_REG=1): directed scenarios plus
// randomized traffic compared against an array-based reference model.
module tb_gpr_file;

  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic             CLK;
  logic             CLR;
  logic             WE;
  logic [AW-1:0]    WADDR;
  logic [WIDTH-1:0] WDATA;
  logic             INC;
  logic [AW-1:0]    IADDR;
  logic [AW-1:0]    RADDR_A;
  logic [WIDTH-1:0] RDATA_A;
  logic [AW-1:0]    RADDR_B;
  logic [WIDTH-1:0] RDATA_B;
  logic             INC_WRAP;

  int errors = 0;
  int checks = 0;

  logic [WIDTH-1:0] mdl [DEPTH];
  logic             mwrap;

  gpr_file #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(1)) dut (
    .CLK     (CLK),
    .CLR     (CLR),
    .WE      (WE),
    .WADDR   (WADDR),
    .WDATA   (WDATA),
    .INC     (INC),
    .IADDR   (IADDR),
    .RADDR_A (RADDR_A),
    .RDATA_A (RDATA_A),
    .RADDR_B (RADDR_B),
    .RDATA_B (RDATA_B),
    .INC_WRAP(INC_WRAP)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Expected read value from the model, given the inputs currently applied.
  function automatic logic [WIDTH-1:0] exp_read(input logic [AW-1:0] addr);
`ifdef GPR_BYPASS_EN
    if (!CLR) begin
      if (WE && addr == WADDR && addr != 0) return WDATA;
      if (INC && addr == IADDR && addr != 0 && !(WE && WADDR == IADDR)) return mdl[addr] + 32'd1;
    end
`endif
    return mdl[addr];
  endfunction

  // Advance one clock edge and move the model to the state the rules define.
  task automatic cycle();
    logic [WIDTH-1:0] nxt [DEPTH];
    logic             nwrap;
    nxt   = mdl;
    nwrap = 1'b0;
    if (CLR) begin
      for (int i = 0; i < DEPTH; i++) nxt[i] = '0;
    end else begin
      if (INC && IADDR != 0 && !(WE && WADDR == IADDR)) begin
        nwrap      = (mdl[IADDR] == 32'hFFFF_FFFF);
        nxt[IADDR] = mdl[IADDR] + 32'd1;
      end
      if (WE && WADDR != 0) nxt[WADDR] = WDATA;
    end
    @(posedge CLK);
    #1;
    mdl   = nxt;
    mwrap = nwrap;
  endtask

  task automatic idle_inputs();
    CLR = 1'b0; WE = 1'b0; INC = 1'b0;
    WADDR = '0; WDATA = '0; IADDR = '0;
  endtask

  task automatic write_reg(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    idle_inputs();
    WE = 1'b1; WADDR = a; WDATA = d;
    cycle();
    idle_inputs();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 6; i++) write_reg(AW'($urandom_range(1, 15)), $urandom);
    CLR = 1'b1; WE = 1'b1; WADDR = 4'd5; WDATA = 32'h1111_2222; INC = 1'b1; IADDR = 4'd6;
    cycle();
    idle_inputs();
    for (int a = 0; a < DEPTH; a++) begin
      RADDR_A = AW'(a); RADDR_B = AW'(DEPTH - 1 - a);
      #1;
      checks++;
      if (RDATA_A !== 32'h0 || RDATA_B !== 32'h0) begin
        errors++;
        $display("FAIL reset_read a=%0d got A=%h B=%h want 0", a, RDATA_A, RDATA_B);
      end
    end
    checks++;
    if (INC_WRAP !== 1'b0) begin
      errors++;
      $display("FAIL reset_wrap got %b want 0", INC_WRAP);
    end
  endtask

  task automatic test_write_read();
    write_reg(4'd5, 32'hDEAD_BEEF);
    RADDR_A = 4'd5; RADDR_B = 4'd5;
    #1;
    checks++;
    if (RDATA_A !== 32'hDEAD_BEEF || RDATA_B !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL write_read got A=%h B=%h want deadbeef", RDATA_A, RDATA_B);
    end
    RADDR_A = 4'd6;
    #1;
    checks++;
    if (RDATA_A !== 32'h0) begin
      errors++;
      $display("FAIL write_neighbour got %h want 0", RDATA_A);
    end
  endtask

  task automatic test_inc_wrap();
    logic [WIDTH-1:0] want [2];
    logic             wrap_want [2];
    want[0] = 32'hFFFF_FFFF; want[1] = 32'h0;
    wrap_want[0] = 1'b0;     wrap_want[1] = 1'b1;
    write_reg(4'd3, 32'hFFFF_FFFE);
    RADDR_A = 4'd3; RADDR_B = 4'd3;
    for (int k = 0; k < 2; k++) begin
      INC = 1'b1; IADDR = 4'd3;
      cycle();
      idle_inputs();
      #1;
      checks++;
      if (RDATA_A !== want[k] || INC_WRAP !== wrap_want[k]) begin
        errors++;
        $display("FAIL inc_step%0d got data=%h wrap=%b want data=%h wrap=%b",
                 k, RDATA_A, INC_WRAP, want[k], wrap_want[k]);
      end
    end
    cycle();
    checks++;
    if (INC_WRAP !== 1'b0) begin
      errors++;
      $display("FAIL wrap_pulse_len got %b want 0", INC_WRAP);
    end
  endtask

  task automatic test_collision();
    write_reg(4'd7, 32'h10);
    write_reg(4'd8, 32'h1);
    WE = 1'b1; WADDR = 4'd7; WDATA = 32'h55; INC = 1'b1; IADDR = 4'd7;
    cycle();
    idle_inputs();
    RADDR_A = 4'd7;
    #1;
    checks++;
    if (RDATA_A !== 32'h55) begin
      errors++;
      $display("FAIL collision_same got %h want 00000055", RDATA_A);
    end
    WE = 1'b1; WADDR = 4'd7; WDATA = 32'h66; INC = 1'b1; IADDR = 4'd8;
    cycle();
    idle_inputs();
    RADDR_A = 4'd7; RADDR_B = 4'd8;
    #1;
    checks++;
    if (RDATA_A !== 32'h66 || RDATA_B !== 32'h2) begin
      errors++;
      $display("FAIL collision_diff got r7=%h r8=%h want 66/2", RDATA_A, RDATA_B);
    end
    write_reg(4'd7, 32'hFFFF_FFFF);
    WE = 1'b1; WADDR = 4'd7; WDATA = 32'h77; INC = 1'b1; IADDR = 4'd7;
    cycle();
    idle_inputs();
    checks++;
    if (INC_WRAP !== 1'b0) begin
      errors++;
      $display("FAIL collision_wrap got %b want 0", INC_WRAP);
    end
  endtask

  task automatic test_zero_reg();
    write_reg(4'd0, 32'h1234);
    RADDR_A = 4'd0; RADDR_B = 4'd0;
    #1;
    checks++;
    if (RDATA_A !== 32'h0 || RDATA_B !== 32'h0) begin
      errors++;
      $display("FAIL zero_write got A=%h B=%h want 0", RDATA_A, RDATA_B);
    end
    INC = 1'b1; IADDR = 4'd0;
    cycle();
    idle_inputs();
    #1;
    checks++;
    if (RDATA_A !== 32'h0 || INC_WRAP !== 1'b0) begin
      errors++;
      $display("FAIL zero_inc got data=%h wrap=%b want 0/0", RDATA_A, INC_WRAP);
    end
  endtask

  task automatic test_bypass();
    logic [WIDTH-1:0] same_cycle;
`ifdef GPR_BYPASS_EN
    same_cycle = 32'hA5A5_A5A5;
`else
    same_cycle = 32'h1111_1111;
`endif
    write_reg(4'd9, 32'h1111_1111);
    WE = 1'b1; WADDR = 4'd9; WDATA = 32'hA5A5_A5A5; RADDR_A = 4'd9;
    #1;
    checks++;
    if (RDATA_A !== same_cycle) begin
      errors++;
      $display("FAIL bypass_same_cycle got %h want %h", RDATA_A, same_cycle);
    end
    cycle();
    idle_inputs();
    #1;
    checks++;
    if (RDATA_A !== 32'hA5A5_A5A5) begin
      errors++;
      $display("FAIL bypass_next_cycle got %h want a5a5a5a5", RDATA_A);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      CLR     = ($urandom_range(0, 39) == 0);
      WE      = $urandom_range(0, 1) == 1;
      INC     = $urandom_range(0, 1) == 1;
      WADDR   = AW'($urandom);
      IADDR   = ($urandom_range(0, 3) == 0) ? WADDR : AW'($urandom);
      // Bias data toward the top of the range so wraps occur often.
      WDATA   = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 2)) : $urandom;
      RADDR_A = ($urandom_range(0, 2) == 0) ? WADDR : AW'($urandom);
      RADDR_B = ($urandom_range(0, 2) == 0) ? IADDR : AW'($urandom);
      #1;
      checks++;
      if (RDATA_A !== exp_read(RADDR_A) || RDATA_B !== exp_read(RADDR_B)) begin
        errors++;
        $display("FAIL rand_read n=%0d a=%0d got %h want %h b=%0d got %h want %h", n,
                 RADDR_A, RDATA_A, exp_read(RADDR_A), RADDR_B, RDATA_B, exp_read(RADDR_B));
      end
      cycle();
      checks++;
      if (INC_WRAP !== mwrap) begin
        errors++;
        $display("FAIL rand_wrap n=%0d got %b want %b", n, INC_WRAP, mwrap);
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    RADDR_A = '0; RADDR_B = '0;
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    mwrap = 1'b0;
    CLR = 1'b1;
    cycle();
    idle_inputs();
    test_reset();
    test_write_read();
    test_inc_wrap();
    test_collision();
    test_zero_reg();
    test_bypass();
    test_random();
    test_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
